lc3_sequencer: RTL and testbench
================================

LC3_SEQUENCER -- requirements
Module: lc3_sequencer

Interface
REQ-001 Parameter WIDTH, default 16, is the instruction and data width; the block SHALL support any WIDTH >= 16, with the opcode at IR[WIDTH-1:WIDTH-4].
REQ-002 Parameter MEM_TIMEOUT, default 15, is the maximum number of wait cycles per memory access before abort; the legal range SHALL be 1..255.
REQ-003 The block SHALL use one clock; reset is synchronous and active-low. Ports: CLK  in  1  clock.
REQ-004 RESET_N  in  1  synchronous active-low reset.
REQ-005 IR  in  WIDTH  current instruction register contents.
REQ-006 MEM_READY  in  1  memory completes the current request this cycle.
REQ-007 RESULT  in  WIDTH  value being written to RD; used for condition-code update.
REQ-008 STAGE  out  3  current state encoding, for debug.
REQ-009 Strobes, all out 1: IR_LE, PC_LE, PC_CONTROL, MAR_LE, MAR_CONTROL (1 = address from PC, 0 = EA), MEM_REQ, MEM_WE, RD_LE, REG_CONTROL (1 = RD from memory data).
REQ-010 ALU_CONTROL  out  3, ALU_MuxA  out  1, ALU_MuxB  out  3  datapath selects.
REQ-011 N, Z, P  out  1 each  registered condition codes.
REQ-012 TIMEOUT  out  1  one-cycle pulse on memory abort; INSTR_DONE  out  1  one-cycle pulse when an instruction retires.

Function
REQ-013 The FSM SHALL have the states FETCH, DECODE, EXECUTE, MEM and WRITEBACK; FETCH is the reset state.
REQ-014 FETCH: MEM_REQ=1 and MAR_CONTROL=1; with MEM_READY=1 the block SHALL assert IR_LE in the same cycle and move to DECODE; otherwise it stays in FETCH.
REQ-015 DECODE: ALU_CONTROL SHALL be AND=001, NOT=010, and for opcode 1101 either IR[5] ? 100 : {1,IR[4:3]}; all other opcodes SHALL give 000.
REQ-016 DECODE: ALU_MuxA=0 for BR and LEA, else 1; ALU_MuxB=100 for ADD/MUL with IR[5]=1, 101 for LDR/STR/LEA, 110 for BR, else 000; MAR_LE=1 for LDR/STR.
REQ-017 Outside DECODE, ALU_CONTROL SHALL be 000, ALU_MuxA 1, ALU_MuxB 000 and MAR_LE 0.
REQ-018 EXECUTE: PC_LE=1; PC_CONTROL=1 for JMP, JSR, TRAP and RTI, and for BR when (IR[11]&N)|(IR[10]&Z)|(IR[9]&P); otherwise PC_CONTROL=0.
REQ-019 EXECUTE next state: LDR/STR -> MEM; BR, JMP, RTI -> FETCH with INSTR_DONE=1; all others -> WRITEBACK.
REQ-020 MEM: MEM_REQ=1 and MAR_CONTROL=0; MEM_WE=1 for STR only.
REQ-021 MEM exit on MEM_READY=1: STR -> FETCH with INSTR_DONE=1; LDR -> WRITEBACK.
REQ-022 WRITEBACK: RD_LE=1 and REG_CONTROL=(opcode==LDR); the state SHALL last exactly one cycle and then go to FETCH with INSTR_DONE=1.
REQ-023 In WRITEBACK, {N,Z,P} SHALL load {RESULT[WIDTH-1], RESULT==0, !RESULT[WIDTH-1] & RESULT!=0} at the clock edge; N, Z and P SHALL not change at any other time.
REQ-024 A wait counter SHALL clear on entry to FETCH or MEM and increment on each cycle with MEM_REQ=1 and MEM_READY=0.
REQ-025 When the wait counter reaches MEM_TIMEOUT with MEM_READY=0, the block SHALL pulse TIMEOUT, drive MEM_REQ=0 that cycle, and go to FETCH; IR, PC and RD are not loaded.
REQ-026 When MEM_READY=1 in the same cycle the counter reaches MEM_TIMEOUT, completion SHALL win and no TIMEOUT pulse is produced.
REQ-027 MEM_READY outside FETCH and MEM SHALL be ignored.

Reset
REQ-028 With RESET_N=0 at a clock edge: state=FETCH, wait counter=0, {N,Z,P}=010, TIMEOUT=0, INSTR_DONE=0.
REQ-029 During the reset cycle all strobes SHALL be 0, including MEM_REQ.
REQ-030 A reset mid-instruction SHALL abandon the instruction; FETCH begins on the first cycle with RESET_N=1.

Structure
REQ-031 Opcode constants, state encodings and ALU/mux select codes SHALL live in the shared package lc3_pkg.
REQ-032 Opcode-to-select decode SHALL be the combinational sub-module lc3_decode; the FSM, wait counter and condition-code registers SHALL stay in lc3_sequencer.

Verification
REQ-033 ADD R1,R2,#3 (0x12A3), MEM_READY=1 in FETCH: the bench SHALL see DECODE with ALU_MuxB=100, then EXECUTE, then WRITEBACK with RD_LE=1; RESULT=0 gives NZP=010 and INSTR_DONE after 4 cycles.
REQ-034 LDR 0x6042, MEM_READY held 0 for 3 MEM cycles: the bench SHALL see MEM_REQ=1 for 4 cycles, then WRITEBACK with REG_CONTROL=1; RESULT=0x8000 gives NZP=100.
REQ-035 BRz 0x0405 with Z=1: the bench SHALL see PC_CONTROL=1 in EXECUTE, no WRITEBACK, and INSTR_DONE on leaving EXECUTE; with Z=0, PC_CONTROL=0.
REQ-036 STR 0x7042 with MEM_TIMEOUT=15 and MEM_READY stuck at 0: the bench SHALL see a TIMEOUT pulse on the 15th wait cycle, MEM_WE=0 after it, and a return to FETCH with no INSTR_DONE.
REQ-037 MEM_READY rising on exactly the 15th wait cycle SHALL give completion with no TIMEOUT.
REQ-038 RESET_N=0 asserted while in MEM: the next state SHALL be FETCH, NZP=010 and all strobes 0.

Source files
------------

// File: rtl/lc3_pkg.sv
// Shared constants for the LC-3 control sequencer: states, opcodes, select codes.
package lc3_pkg;

  typedef enum logic [2:0] {
    ST_FETCH     = 3'd0,
    ST_DECODE    = 3'd1,
    ST_EXECUTE   = 3'd2,
    ST_MEM       = 3'd3,
    ST_WRITEBACK = 3'd4
  } state_e;

  typedef enum logic [3:0] {
    OP_BR   = 4'h0,
    OP_ADD  = 4'h1,
    OP_LD   = 4'h2,
    OP_ST   = 4'h3,
    OP_JSR  = 4'h4,
    OP_AND  = 4'h5,
    OP_LDR  = 4'h6,
    OP_STR  = 4'h7,
    OP_RTI  = 4'h8,
    OP_NOT  = 4'h9,
    OP_LDI  = 4'hA,
    OP_STI  = 4'hB,
    OP_JMP  = 4'hC,
    OP_MUL  = 4'hD,
    OP_LEA  = 4'hE,
    OP_TRAP = 4'hF
  } opcode_e;

  // ALU operation selects
  localparam logic [2:0] ALU_PASS    = 3'b000;
  localparam logic [2:0] ALU_AND     = 3'b001;
  localparam logic [2:0] ALU_NOT     = 3'b010;
  localparam logic [2:0] ALU_MUL_IMM = 3'b100;

  // ALU operand A source
  localparam logic MUXA_PC  = 1'b0;
  localparam logic MUXA_REG = 1'b1;

  // ALU operand B source
  localparam logic [2:0] MUXB_REG  = 3'b000;
  localparam logic [2:0] MUXB_IMM5 = 3'b100;
  localparam logic [2:0] MUXB_OFF6 = 3'b101;
  localparam logic [2:0] MUXB_OFF9 = 3'b110;

  // Wait counter width; covers the full 1..255 timeout range
  localparam int WAIT_W = 8;

  function automatic opcode_e get_opcode(input logic [3:0] bits);
    return opcode_e'(bits);
  endfunction

endpackage

// File: rtl/lc3_decode.sv
// Combinational opcode-to-datapath-select decode used during DECODE.
module lc3_decode
  import lc3_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH-1:0] ir,
  output logic [2:0]       alu_control,
  output logic             alu_mux_a,
  output logic [2:0]       alu_mux_b,
  output logic             mar_le
);

  opcode_e op;
  logic    unused_ir;

  assign op        = get_opcode(ir[WIDTH-1:WIDTH-4]);
  assign unused_ir = ^ir;

  // Select codes as a pure function of the opcode and mode bits
  always_comb begin
    alu_control = ALU_PASS;
    alu_mux_a   = MUXA_REG;
    alu_mux_b   = MUXB_REG;
    mar_le      = 1'b0;

    case (op)
      OP_AND: alu_control = ALU_AND;
      OP_NOT: alu_control = ALU_NOT;
      OP_MUL: alu_control = ir[5] ? ALU_MUL_IMM : {1'b1, ir[4:3]};
      default: alu_control = ALU_PASS;
    endcase

    if (op == OP_BR || op == OP_LEA) alu_mux_a = MUXA_PC;

    if ((op == OP_ADD || op == OP_MUL) && ir[5])         alu_mux_b = MUXB_IMM5;
    else if (op == OP_LDR || op == OP_STR || op == OP_LEA) alu_mux_b = MUXB_OFF6;
    else if (op == OP_BR)                                alu_mux_b = MUXB_OFF9;

    mar_le = (op == OP_LDR) || (op == OP_STR);
  end

endmodule

// File: rtl/lc3_sequencer.sv
// LC-3 control sequencer: FETCH/DECODE/EXECUTE/MEM/WRITEBACK FSM with
// memory wait timeout and condition-code registers.
module lc3_sequencer
  import lc3_pkg::*;
#(
  parameter int WIDTH       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             CLK,
  input  logic             RESET_N,
  input  logic [WIDTH-1:0] IR,
  input  logic             MEM_READY,
  input  logic [WIDTH-1:0] RESULT,
  output logic [2:0]       STAGE,
  output logic             IR_LE,
  output logic             PC_LE,
  output logic             PC_CONTROL,
  output logic             MAR_LE,
  output logic             MAR_CONTROL,
  output logic             MEM_REQ,
  output logic             MEM_WE,
  output logic             RD_LE,
  output logic             REG_CONTROL,
  output logic [2:0]       ALU_CONTROL,
  output logic             ALU_MuxA,
  output logic [2:0]       ALU_MuxB,
  output logic             N,
  output logic             Z,
  output logic             P,
  output logic             TIMEOUT,
  output logic             INSTR_DONE
);

  // Counter value seen in the cycle of the MEM_TIMEOUT-th wait
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MEM_TIMEOUT - 1);

  state_e              state_q, state_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic [2:0]          nzp_q, nzp_d;
  opcode_e             op;

  logic [2:0]          dec_alu_control;
  logic                dec_alu_mux_a;
  logic [2:0]          dec_alu_mux_b;
  logic                dec_mar_le;

  assign op        = get_opcode(IR[WIDTH-1:WIDTH-4]);
  assign STAGE     = state_q;
  assign {N, Z, P} = nzp_q;

  lc3_decode #(.WIDTH(WIDTH)) u_decode (
    .ir          (IR),
    .alu_control (dec_alu_control),
    .alu_mux_a   (dec_alu_mux_a),
    .alu_mux_b   (dec_alu_mux_b),
    .mar_le      (dec_mar_le)
  );

  // Next state, strobes, wait counter and condition-code next values
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    nzp_d       = nzp_q;
    IR_LE       = 1'b0;
    PC_LE       = 1'b0;
    PC_CONTROL  = 1'b0;
    MAR_LE      = 1'b0;
    MAR_CONTROL = 1'b0;
    MEM_REQ     = 1'b0;
    MEM_WE      = 1'b0;
    RD_LE       = 1'b0;
    REG_CONTROL = 1'b0;
    ALU_CONTROL = ALU_PASS;
    ALU_MuxA    = MUXA_REG;
    ALU_MuxB    = MUXB_REG;
    TIMEOUT     = 1'b0;
    INSTR_DONE  = 1'b0;

    case (state_q)
      ST_FETCH: begin
        MAR_CONTROL = 1'b1;
        MEM_REQ     = 1'b1;
        if (MEM_READY) begin
          IR_LE   = 1'b1;
          state_d = ST_DECODE;
        end else if (wait_q == WAIT_LAST) begin
          MEM_REQ = 1'b0;
          TIMEOUT = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_DECODE: begin
        ALU_CONTROL = dec_alu_control;
        ALU_MuxA    = dec_alu_mux_a;
        ALU_MuxB    = dec_alu_mux_b;
        MAR_LE      = dec_mar_le;
        state_d     = ST_EXECUTE;
      end

      ST_EXECUTE: begin
        PC_LE = 1'b1;
        case (op)
          OP_JMP, OP_JSR, OP_TRAP, OP_RTI: PC_CONTROL = 1'b1;
          OP_BR: PC_CONTROL = |(IR[11:9] & nzp_q);
          default: PC_CONTROL = 1'b0;
        endcase
        case (op)
          OP_LDR, OP_STR: state_d = ST_MEM;
          OP_BR, OP_JMP, OP_RTI: begin
            INSTR_DONE = 1'b1;
            state_d    = ST_FETCH;
          end
          default: state_d = ST_WRITEBACK;
        endcase
      end

      ST_MEM: begin
        MEM_REQ = 1'b1;
        MEM_WE  = (op == OP_STR);
        if (MEM_READY) begin
          if (op == OP_STR) begin
            INSTR_DONE = 1'b1;
            state_d    = ST_FETCH;
          end else begin
            state_d = ST_WRITEBACK;
          end
        end else if (wait_q == WAIT_LAST) begin
          MEM_REQ = 1'b0;
          MEM_WE  = 1'b0;
          TIMEOUT = 1'b1;
          state_d = ST_FETCH;
        end
      end

      ST_WRITEBACK: begin
        RD_LE       = 1'b1;
        REG_CONTROL = (op == OP_LDR);
        INSTR_DONE  = 1'b1;
        nzp_d       = {RESULT[WIDTH-1], RESULT == '0, !RESULT[WIDTH-1] && (RESULT != '0)};
        state_d     = ST_FETCH;
      end

      default: state_d = ST_FETCH;
    endcase

    // Any state change (or a FETCH-to-FETCH timeout retry) starts a fresh wait count
    if (state_d != state_q || TIMEOUT) begin
      wait_d = '0;
    end else if (MEM_REQ && !MEM_READY) begin
      wait_d = wait_q + WAIT_W'(1);
    end

    if (!RESET_N) begin
      IR_LE       = 1'b0;
      PC_LE       = 1'b0;
      PC_CONTROL  = 1'b0;
      MAR_LE      = 1'b0;
      MAR_CONTROL = 1'b0;
      MEM_REQ     = 1'b0;
      MEM_WE      = 1'b0;
      RD_LE       = 1'b0;
      REG_CONTROL = 1'b0;
      TIMEOUT     = 1'b0;
      INSTR_DONE  = 1'b0;
    end
  end

  // State, wait counter and condition-code registers
  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      state_q <= ST_FETCH;
      wait_q  <= '0;
      nzp_q   <= 3'b010;
    end else begin
      state_q <= state_d;
      wait_q  <= wait_d;
      nzp_q   <= nzp_d;
    end
  end

endmodule

// File: tb/tb_lc3_sequencer.sv
// Self-checking bench for lc3_sequencer: directed scenarios plus a randomized
// instruction stream checked against an instruction-level reference model.
module tb_lc3_sequencer;
  import lc3_pkg::*;

  localparam int W   = 16;
  localparam int TMO = 15;

  logic         CLK = 1'b0;
  logic         RESET_N = 1'b0;
  logic [W-1:0] IR = '0;
  logic         MEM_READY = 1'b0;
  logic [W-1:0] RESULT = '0;
  logic [2:0]   STAGE;
  logic         IR_LE, PC_LE, PC_CONTROL, MAR_LE, MAR_CONTROL, MEM_REQ, MEM_WE, RD_LE, REG_CONTROL;
  logic [2:0]   ALU_CONTROL;
  logic         ALU_MuxA;
  logic [2:0]   ALU_MuxB;
  logic         N, Z, P, TIMEOUT, INSTR_DONE;

  int total = 0;
  int bad   = 0;
  logic [2:0] m_nzp = 3'b010;

  logic [8:0]  strobes;
  logic [23:0] obs;
  assign strobes = {IR_LE, PC_LE, PC_CONTROL, MAR_LE, MAR_CONTROL, MEM_REQ, MEM_WE, RD_LE, REG_CONTROL};
  assign obs = {STAGE, strobes, ALU_CONTROL, ALU_MuxA, ALU_MuxB, N, Z, P, TIMEOUT, INSTR_DONE};

  lc3_sequencer #(.WIDTH(W), .MEM_TIMEOUT(TMO)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .IR(IR), .MEM_READY(MEM_READY), .RESULT(RESULT),
    .STAGE(STAGE), .IR_LE(IR_LE), .PC_LE(PC_LE), .PC_CONTROL(PC_CONTROL), .MAR_LE(MAR_LE),
    .MAR_CONTROL(MAR_CONTROL), .MEM_REQ(MEM_REQ), .MEM_WE(MEM_WE), .RD_LE(RD_LE),
    .REG_CONTROL(REG_CONTROL), .ALU_CONTROL(ALU_CONTROL), .ALU_MuxA(ALU_MuxA),
    .ALU_MuxB(ALU_MuxB), .N(N), .Z(Z), .P(P), .TIMEOUT(TIMEOUT), .INSTR_DONE(INSTR_DONE)
  );

  always #5 CLK = ~CLK;

  // Expected outputs for one cycle, from the per-phase rules of the sequencer.
  // Strobe order: IR_LE PC_LE PC_CONTROL MAR_LE MAR_CONTROL MEM_REQ MEM_WE RD_LE REG_CONTROL
  function automatic logic [23:0] m_exp(input logic [2:0] stg, input logic [15:0] ir,
                                        input logic rdy, input logic tmo, input logic [2:0] nzp);
    logic [3:0] op;
    logic [8:0] s;
    logic [2:0] alu, mb;
    logic       ma, done;
    op = ir[15:12]; s = '0; alu = 3'b000; ma = 1'b1; mb = 3'b000; done = 1'b0;
    case (stg)
      ST_FETCH: begin s[4] = 1'b1; s[3] = !tmo; s[8] = rdy; end
      ST_DECODE: begin
        if (op == 4'h5) alu = 3'b001;
        else if (op == 4'h9) alu = 3'b010;
        else if (op == 4'hD) alu = ir[5] ? 3'b100 : {1'b1, ir[4:3]};
        ma = !(op == 4'h0 || op == 4'hE);
        if ((op == 4'h1 || op == 4'hD) && ir[5]) mb = 3'b100;
        else if (op == 4'h6 || op == 4'h7 || op == 4'hE) mb = 3'b101;
        else if (op == 4'h0) mb = 3'b110;
        s[5] = (op == 4'h6 || op == 4'h7);
      end
      ST_EXECUTE: begin
        s[7] = 1'b1;
        s[6] = (op == 4'hC || op == 4'h4 || op == 4'hF || op == 4'h8) ||
               (op == 4'h0 && ((ir[11] && nzp[2]) || (ir[10] && nzp[1]) || (ir[9] && nzp[0])));
        done = (op == 4'h0 || op == 4'hC || op == 4'h8);
      end
      ST_MEM: begin s[3] = !tmo; s[2] = (op == 4'h7) && !tmo; done = rdy && op == 4'h7; end
      ST_WRITEBACK: begin s[1] = 1'b1; s[0] = (op == 4'h6); done = 1'b1; end
      default: ;
    endcase
    return {stg, s, alu, ma, mb, nzp, tmo, done};
  endfunction

  function automatic logic [2:0] m_cc(input logic [15:0] r);
    if ($signed(r) < 0) return 3'b100;
    else if (r == 16'd0) return 3'b010;
    else return 3'b001;
  endfunction

  task automatic test_reset;
    MEM_READY = 1'b1; IR = 16'h12A3; #1;
    total++; if (STAGE !== ST_FETCH) begin bad++; $display("FAIL reset_stage got=%0d want=%0d", STAGE, ST_FETCH); end
    total++; if (strobes !== 9'd0) begin bad++; $display("FAIL reset_strobes got=%b want=000000000", strobes); end
    total++; if ({N, Z, P, TIMEOUT, INSTR_DONE} !== 5'b01000) begin bad++; $display("FAIL reset_nzp_pulses got=%b want=01000", {N, Z, P, TIMEOUT, INSTR_DONE}); end
    RESET_N = 1'b1; MEM_READY = 1'b0; #1;
    total++; if (STAGE !== ST_FETCH || MEM_REQ !== 1'b1 || MAR_CONTROL !== 1'b1) begin bad++; $display("FAIL reset_release_fetch stage=%0d memreq=%b marc=%b want FETCH 1 1", STAGE, MEM_REQ, MAR_CONTROL); end
    @(negedge CLK); RESET_N = 1'b0;
    @(negedge CLK); RESET_N = 1'b1;
    m_nzp = 3'b010;
  endtask

  task automatic test_ldr;
    IR = 16'h6042; MEM_READY = 1'b1; #1;
    total++; if (STAGE !== ST_FETCH || IR_LE !== 1'b1 || MEM_REQ !== 1'b1) begin bad++; $display("FAIL ldr_fetch stage=%0d irle=%b memreq=%b want 0 1 1", STAGE, IR_LE, MEM_REQ); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_DECODE || MAR_LE !== 1'b1 || ALU_MuxB !== 3'b101) begin bad++; $display("FAIL ldr_decode stage=%0d marle=%b muxb=%b want 1 1 101", STAGE, MAR_LE, ALU_MuxB); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_EXECUTE || PC_LE !== 1'b1 || PC_CONTROL !== 1'b0 || INSTR_DONE !== 1'b0) begin bad++; $display("FAIL ldr_execute stage=%0d pcle=%b pcc=%b done=%b want 2 1 0 0", STAGE, PC_LE, PC_CONTROL, INSTR_DONE); end
    @(negedge CLK);
    for (int i = 0; i < 4; i++) begin
      MEM_READY = (i == 3); #1;
      total++; if (STAGE !== ST_MEM || MEM_REQ !== 1'b1 || MEM_WE !== 1'b0 || MAR_CONTROL !== 1'b0) begin bad++; $display("FAIL ldr_mem%0d stage=%0d memreq=%b we=%b marc=%b want 3 1 0 0", i, STAGE, MEM_REQ, MEM_WE, MAR_CONTROL); end
      @(negedge CLK);
    end
    RESULT = 16'h8000; MEM_READY = 1'b0; #1;
    total++; if (STAGE !== ST_WRITEBACK || RD_LE !== 1'b1 || REG_CONTROL !== 1'b1 || INSTR_DONE !== 1'b1) begin bad++; $display("FAIL ldr_wb stage=%0d rdle=%b regc=%b done=%b want 4 1 1 1", STAGE, RD_LE, REG_CONTROL, INSTR_DONE); end
    @(negedge CLK); #1;
    m_nzp = 3'b100;
    total++; if ({N, Z, P} !== 3'b100 || STAGE !== ST_FETCH) begin bad++; $display("FAIL ldr_nzp nzp=%b stage=%0d want 100 0", {N, Z, P}, STAGE); end
  endtask

  task automatic test_add;
    IR = 16'h12A3; MEM_READY = 1'b1; #1;
    total++; if (IR_LE !== 1'b1) begin bad++; $display("FAIL add_fetch irle=%b want 1", IR_LE); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_DECODE || ALU_MuxB !== 3'b100 || ALU_MuxA !== 1'b1 || ALU_CONTROL !== 3'b000) begin bad++; $display("FAIL add_decode stage=%0d muxb=%b muxa=%b alu=%b want 1 100 1 000", STAGE, ALU_MuxB, ALU_MuxA, ALU_CONTROL); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_EXECUTE || MEM_REQ !== 1'b0) begin bad++; $display("FAIL add_execute stage=%0d memreq=%b want 2 0", STAGE, MEM_REQ); end
    @(negedge CLK); RESULT = 16'h0000; #1;
    total++; if (STAGE !== ST_WRITEBACK || RD_LE !== 1'b1 || INSTR_DONE !== 1'b1) begin bad++; $display("FAIL add_wb stage=%0d rdle=%b done=%b want 4 1 1", STAGE, RD_LE, INSTR_DONE); end
    @(negedge CLK); #1;
    m_nzp = 3'b010;
    total++; if ({N, Z, P} !== 3'b010 || INSTR_DONE !== 1'b0) begin bad++; $display("FAIL add_nzp nzp=%b done=%b want 010 0", {N, Z, P}, INSTR_DONE); end
  endtask

  task automatic test_branch;
    IR = 16'h0405; MEM_READY = 1'b1; #1;
    @(negedge CLK); #1;
    total++; if (ALU_MuxA !== 1'b0 || ALU_MuxB !== 3'b110) begin bad++; $display("FAIL br_decode muxa=%b muxb=%b want 0 110", ALU_MuxA, ALU_MuxB); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_EXECUTE || PC_CONTROL !== 1'b1 || INSTR_DONE !== 1'b1) begin bad++; $display("FAIL brz_taken stage=%0d pcc=%b done=%b want 2 1 1", STAGE, PC_CONTROL, INSTR_DONE); end
    @(negedge CLK); #1;
    total++; if (STAGE !== ST_FETCH) begin bad++; $display("FAIL brz_no_wb stage=%0d want 0", STAGE); end
    // positive ADD result clears Z
    IR = 16'h12A3; MEM_READY = 1'b1;
    repeat (3) @(negedge CLK);
    RESULT = 16'h0005; #1;
    @(negedge CLK); #1;
    m_nzp = 3'b001;
    total++; if ({N, Z, P} !== 3'b001) begin bad++; $display("FAIL add_pos_nzp nzp=%b want 001", {N, Z, P}); end
    IR = 16'h0405; MEM_READY = 1'b1;
    repeat (2) @(negedge CLK);
    #1;
    total++; if (STAGE !== ST_EXECUTE || PC_CONTROL !== 1'b0 || INSTR_DONE !== 1'b1) begin bad++; $display("FAIL brz_not_taken stage=%0d pcc=%b done=%b want 2 0 1", STAGE, PC_CONTROL, INSTR_DONE); end
    @(negedge CLK);
  endtask

  task automatic test_str_timeout;
    IR = 16'h7042; MEM_READY = 1'b1;
    repeat (3) @(negedge CLK);
    MEM_READY = 1'b0;
    for (int i = 1; i <= TMO; i++) begin
      #1;
      if (i < TMO) begin
        total++; if (STAGE !== ST_MEM || MEM_REQ !== 1'b1 || MEM_WE !== 1'b1 || TIMEOUT !== 1'b0) begin bad++; $display("FAIL str_wait%0d stage=%0d memreq=%b we=%b to=%b want 3 1 1 0", i, STAGE, MEM_REQ, MEM_WE, TIMEOUT); end
      end else begin
        total++; if (TIMEOUT !== 1'b1 || MEM_REQ !== 1'b0 || MEM_WE !== 1'b0 || INSTR_DONE !== 1'b0) begin bad++; $display("FAIL str_timeout to=%b memreq=%b we=%b done=%b want 1 0 0 0", TIMEOUT, MEM_REQ, MEM_WE, INSTR_DONE); end
      end
      @(negedge CLK);
    end
    #1;
    total++; if (STAGE !== ST_FETCH || TIMEOUT !== 1'b0 || MEM_WE !== 1'b0 || INSTR_DONE !== 1'b0 || {N, Z, P} !== m_nzp) begin bad++; $display("FAIL str_after_timeout stage=%0d to=%b we=%b done=%b nzp=%b want 0 0 0 0 %b", STAGE, TIMEOUT, MEM_WE, INSTR_DONE, {N, Z, P}, m_nzp); end
  endtask

  task automatic test_ready_at_limit;
    IR = 16'h7042; MEM_READY = 1'b1;
    repeat (3) @(negedge CLK);
    for (int i = 1; i <= TMO; i++) begin
      MEM_READY = (i == TMO); #1;
      if (i == TMO) begin
        total++; if (TIMEOUT !== 1'b0 || INSTR_DONE !== 1'b1 || MEM_REQ !== 1'b1 || MEM_WE !== 1'b1) begin bad++; $display("FAIL limit_complete to=%b done=%b memreq=%b we=%b want 0 1 1 1", TIMEOUT, INSTR_DONE, MEM_REQ, MEM_WE); end
      end
      @(negedge CLK);
    end
    #1;
    total++; if (STAGE !== ST_FETCH) begin bad++; $display("FAIL limit_next stage=%0d want 0", STAGE); end
  endtask

  task automatic test_reset_in_mem;
    IR = 16'h6042; MEM_READY = 1'b1;
    repeat (3) @(negedge CLK);
    MEM_READY = 1'b0;
    repeat (2) @(negedge CLK);
    RESET_N = 1'b0; MEM_READY = 1'b1; #1;
    total++; if (STAGE !== ST_MEM || strobes !== 9'd0 || TIMEOUT !== 1'b0 || INSTR_DONE !== 1'b0) begin bad++; $display("FAIL rst_mem_strobes stage=%0d strobes=%b to=%b done=%b want 3 000000000 0 0", STAGE, strobes, TIMEOUT, INSTR_DONE); end
    @(negedge CLK); RESET_N = 1'b1; MEM_READY = 1'b0; #1;
    m_nzp = 3'b010;
    total++; if (STAGE !== ST_FETCH || {N, Z, P} !== 3'b010 || MEM_REQ !== 1'b1) begin bad++; $display("FAIL rst_mem_after stage=%0d nzp=%b memreq=%b want 0 010 1", STAGE, {N, Z, P}, MEM_REQ); end
    RESET_N = 1'b0;
    @(negedge CLK); RESET_N = 1'b1;
  endtask

  task automatic test_random;
    for (int n = 0; n < 60; n++) begin
      logic [15:0] ir;
      logic [3:0]  op;
      logic [23:0] e;
      logic [15:0] res;
      logic        rdy, tmo, go_wb;
      int          w, k;
      op = 4'($urandom_range(0, 15));
      ir = {op, 12'($urandom)};
      IR = ir;
      w = $urandom_range(0, 16); k = 0;
      for (int c = 0; c < 40; c++) begin
        rdy = (k == w); tmo = !rdy && (k == TMO - 1);
        MEM_READY = rdy; #1;
        e = m_exp(ST_FETCH, ir, rdy, tmo, m_nzp);
        total++; if (obs !== e) begin bad++; $display("FAIL rand_fetch ir=%h got=%h want=%h", ir, obs, e); end
        @(negedge CLK);
        if (rdy) break;
        if (tmo) begin k = 0; w = $urandom_range(0, 3); end else k++;
      end
      MEM_READY = 1'($urandom); #1;
      e = m_exp(ST_DECODE, ir, MEM_READY, 1'b0, m_nzp);
      total++; if (obs !== e) begin bad++; $display("FAIL rand_decode ir=%h got=%h want=%h", ir, obs, e); end
      @(negedge CLK);
      MEM_READY = 1'($urandom); #1;
      e = m_exp(ST_EXECUTE, ir, MEM_READY, 1'b0, m_nzp);
      total++; if (obs !== e) begin bad++; $display("FAIL rand_execute ir=%h got=%h want=%h", ir, obs, e); end
      @(negedge CLK);
      go_wb = !(op == 4'h0 || op == 4'hC || op == 4'h8 || op == 4'h7);
      if (op == 4'h6 || op == 4'h7) begin
        w = $urandom_range(0, 16);
        for (int c = 0; c < TMO; c++) begin
          rdy = (c == w); tmo = !rdy && (c == TMO - 1);
          MEM_READY = rdy; #1;
          e = m_exp(ST_MEM, ir, rdy, tmo, m_nzp);
          total++; if (obs !== e) begin bad++; $display("FAIL rand_mem ir=%h cyc=%0d got=%h want=%h", ir, c, obs, e); end
          @(negedge CLK);
          if (tmo) go_wb = 1'b0;
          if (rdy || tmo) break;
        end
      end
      if (go_wb) begin
        case ($urandom_range(0, 3))
          0: res = 16'h0000;
          1: res = {1'b1, 15'($urandom)};
          default: res = 16'($urandom);
        endcase
        RESULT = res; MEM_READY = 1'($urandom); #1;
        e = m_exp(ST_WRITEBACK, ir, MEM_READY, 1'b0, m_nzp);
        total++; if (obs !== e) begin bad++; $display("FAIL rand_wb ir=%h got=%h want=%h", ir, obs, e); end
        @(negedge CLK);
        m_nzp = m_cc(res);
      end
    end
    #1;
    total++; if ({N, Z, P} !== m_nzp || STAGE !== ST_FETCH) begin bad++; $display("FAIL rand_final nzp=%b stage=%0d want %b 0", {N, Z, P}, STAGE, m_nzp); end
  endtask

  initial begin
    @(negedge CLK);
    test_reset();
    test_ldr();
    test_add();
    test_branch();
    test_str_timeout();
    test_ready_at_limit();
    test_reset_in_mem();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
